ti_write_port: RTL and testbench

//  Responder end of the SN76489-style byte-write bus (nCE/nWE/D/READY) inside ti_top.

---
 rtl/ti_pkg.sv | 21 ++
 rtl/ti_byte_decode.sv | 37 +++
 rtl/ti_write_port.sv | 131 +++++++++++++
 tb/tb_ti_write_port.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/ti_pkg.sv
// Shared types and constants for the TI-style sound chip write port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ti_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_REL
    } ti_wp_state_t;

    // Latched register selector: channel plus tone/volume type bit.
    typedef struct packed {
        logic [1:0] ch;
        logic       is_vol;
    } ti_regsel_t;

    localparam logic [3:0] ATT_OFF  = 4'hF;
    localparam logic [1:0] NOISE_CH = 2'd3;

endpackage

// File: rtl/ti_byte_decode.sv
// Decodes one bus byte against the latched selector into register write strobes.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only acts on the strobes during its commit cycle.
// Ports: d (byte), sel (latched selector) -> new_sel, wr_tone_lo, wr_tone_hi,
//        wr_att, wr_noise, ch (target channel).
module ti_byte_decode
    import ti_pkg::*;
(
    input  logic [7:0]  d,
    input  ti_regsel_t  sel,
    output ti_regsel_t  new_sel,
    output logic        wr_tone_lo,
    output logic        wr_tone_hi,
    output logic        wr_att,
    output logic        wr_noise,
    output logic [1:0]  ch
);

    logic       is_latch;
    ti_regsel_t tgt;
    logic       is_noise;

    always_comb begin
        is_latch = d[7];
        // A latch byte re-targets immediately; a data byte uses the held selector.
        tgt      = is_latch ? ti_regsel_t'({d[6:5], d[4]}) : sel;
        is_noise = (tgt.ch == NOISE_CH);

        new_sel    = tgt;
        ch         = tgt.ch;
        wr_att     = tgt.is_vol;
        wr_noise   = !tgt.is_vol && is_noise;
        wr_tone_lo = is_latch  && !tgt.is_vol && !is_noise;
        wr_tone_hi = !is_latch && !tgt.is_vol && !is_noise;
    end

endmodule

// File: rtl/ti_write_port.sv
// Responder for the nCE/nWE/D/READY byte-write bus; owns the tone/atten/noise register file.
// Latency: registers update one cycle after the accepting edge; READY low BUSY_CYCLES cycles.
// Backpressure: READY=0 while busy and until the strobe is released; strobes then are ignored.
// Ports: CLK, RST (sync, active-high), nCE, nWE, D[7:0] in; READY, tone0..2[9:0],
//        atten0..3[3:0], noise_ctrl[2:0], noise_rst out (all registered).
module ti_write_port
    import ti_pkg::*;
#(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       nCE,
    input  logic       nWE,
    input  logic [7:0] D,
    output logic       READY,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] atten0,
    output logic [3:0] atten1,
    output logic [3:0] atten2,
    output logic [3:0] atten3,
    output logic [2:0] noise_ctrl,
    output logic       noise_rst
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

    ti_wp_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       d_q;
    logic             commit_pend;
    ti_regsel_t       sel_q;
    logic             ready_q;
    logic [9:0]       tone_q [3];
    logic [3:0]       att_q  [4];
    logic [2:0]       noise_q;
    logic             noise_rst_q;

    ti_regsel_t new_sel;
    logic       wr_tone_lo;
    logic       wr_tone_hi;
    logic       wr_att;
    logic       wr_noise;
    logic [1:0] wr_ch;
    logic       strobe;

    assign strobe = !nCE && !nWE;

    // Decode works on the captured byte, so no bus input reaches an output combinationally.
    ti_byte_decode u_decode (
        .d          (d_q),
        .sel        (sel_q),
        .new_sel    (new_sel),
        .wr_tone_lo (wr_tone_lo),
        .wr_tone_hi (wr_tone_hi),
        .wr_att     (wr_att),
        .wr_noise   (wr_noise),
        .ch         (wr_ch)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            d_q         <= '0;
            commit_pend <= 1'b0;
            sel_q       <= '0;
            ready_q     <= 1'b1;
            noise_q     <= '0;
            noise_rst_q <= 1'b0;
            for (int i = 0; i < 3; i++) tone_q[i] <= '0;
            for (int i = 0; i < 4; i++) att_q[i]  <= ATT_OFF;
        end else begin
            noise_rst_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (strobe) begin
                        d_q         <= D;
                        ready_q     <= 1'b0;
                        cnt         <= CNT_W'(BUSY_CYCLES - 1);
                        commit_pend <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (commit_pend) begin
                        commit_pend <= 1'b0;
                        sel_q       <= new_sel;
                        for (int i = 0; i < 3; i++) begin
                            if (wr_ch == 2'(i)) begin
                                if (wr_tone_lo) tone_q[i][3:0] <= d_q[3:0];
                                if (wr_tone_hi) tone_q[i][9:4] <= d_q[5:0];
                            end
                        end
                        if (wr_att) att_q[wr_ch] <= d_q[3:0];
                        if (wr_noise) begin
                            noise_q     <= d_q[2:0];
                            noise_rst_q <= 1'b1;
                        end
                    end
                    cnt <= cnt - 1'b1;
                    // Leave on the edge the counter reaches zero, so READY is low
                    // exactly BUSY_CYCLES cycles when the strobe is already released.
                    if (cnt == CNT_W'(1)) state <= WAIT_REL;
                end
                WAIT_REL: begin
                    // A strobe still held low must not be seen as a second write.
                    if (!strobe) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign READY      = ready_q;
    assign tone0      = tone_q[0];
    assign tone1      = tone_q[1];
    assign tone2      = tone_q[2];
    assign atten0     = att_q[0];
    assign atten1     = att_q[1];
    assign atten2     = att_q[2];
    assign atten3     = att_q[3];
    assign noise_ctrl = noise_q;
    assign noise_rst  = noise_rst_q;

endmodule

// File: tb/tb_ti_write_port.sv
// Directed self-checking bench for ti_write_port.
// Latency: n/a.
// Backpressure: n/a.
module tb_ti_write_port;

    localparam int BC = 32;

    logic       CLK;
    logic       RST;
    logic       nCE;
    logic       nWE;
    logic [7:0] D;
    logic       READY;
    logic [9:0] tone0, tone1, tone2;
    logic [3:0] atten0, atten1, atten2, atten3;
    logic [2:0] noise_ctrl;
    logic       noise_rst;

    int total  = 0;
    int passed = 0;

    ti_write_port #(.BUSY_CYCLES(BC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .nCE        (nCE),
        .nWE        (nWE),
        .D          (D),
        .READY      (READY),
        .tone0      (tone0),
        .tone1      (tone1),
        .tone2      (tone2),
        .atten0     (atten0),
        .atten1     (atten1),
        .atten2     (atten2),
        .atten3     (atten3),
        .noise_ctrl (noise_ctrl),
        .noise_rst  (noise_rst)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  d;
        logic [29:0] tones;  // {tone2, tone1, tone0}
        logic [15:0] atts;   // {atten3, atten2, atten1, atten0}
        logic [2:0]  noise;
        int          pulses;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Full handshake: strobe for one edge, release, then count READY-low cycles.
    task automatic write_byte(input logic [7:0] b, output int low, output int pulses);
        @(negedge CLK);
        nCE = 1'b0; nWE = 1'b0; D = b;
        @(negedge CLK);
        nCE = 1'b1; nWE = 1'b1;
        low = 0; pulses = 0;
        while (READY == 1'b0 && low < 200) begin
            low++;
            if (noise_rst) pulses++;
            @(negedge CLK);
        end
    endtask

    initial begin
        int low, pulses;

        vecs[0]  = '{8'h8A, {10'h000, 10'h000, 10'h00A}, 16'hFFFF, 3'd0, 0};
        vecs[1]  = '{8'h0E, {10'h000, 10'h000, 10'h0EA}, 16'hFFFF, 3'd0, 0};
        vecs[2]  = '{8'h91, {10'h000, 10'h000, 10'h0EA}, 16'hFFF1, 3'd0, 0};
        vecs[3]  = '{8'h05, {10'h000, 10'h000, 10'h0EA}, 16'hFFF5, 3'd0, 0};
        vecs[4]  = '{8'hE6, {10'h000, 10'h000, 10'h0EA}, 16'hFFF5, 3'd6, 1};
        vecs[5]  = '{8'h03, {10'h000, 10'h000, 10'h0EA}, 16'hFFF5, 3'd3, 1};
        vecs[6]  = '{8'hAF, {10'h000, 10'h00F, 10'h0EA}, 16'hFFF5, 3'd3, 0};
        vecs[7]  = '{8'h7F, {10'h000, 10'h3FF, 10'h0EA}, 16'hFFF5, 3'd3, 0};
        vecs[8]  = '{8'hDC, {10'h000, 10'h3FF, 10'h0EA}, 16'hFCF5, 3'd3, 0};
        vecs[9]  = '{8'hF7, {10'h000, 10'h3FF, 10'h0EA}, 16'h7CF5, 3'd3, 0};
        vecs[10] = '{8'h4A, {10'h000, 10'h3FF, 10'h0EA}, 16'hACF5, 3'd3, 0};

        RST = 1'b1; nCE = 1'b1; nWE = 1'b1; D = 8'h00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset state
        check("rst_ready", 32'(READY), 32'd1);
        check("rst_tones", 32'({tone2, tone1, tone0}), 32'd0);
        check("rst_atts",  32'({atten3, atten2, atten1, atten0}), 32'hFFFF);
        check("rst_noise", 32'(noise_ctrl), 32'd0);
        check("rst_nrst",  32'(noise_rst), 32'd0);

        // Table of full-handshake writes, cumulative from reset
        for (int i = 0; i < 11; i++) begin
            write_byte(vecs[i].d, low, pulses);
            check($sformatf("v%0d_low", i),    32'(low), 32'(BC));
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].pulses));
            check($sformatf("v%0d_tones", i),  32'({tone2, tone1, tone0}), 32'(vecs[i].tones));
            check($sformatf("v%0d_atts", i),   32'({atten3, atten2, atten1, atten0}), 32'(vecs[i].atts));
            check($sformatf("v%0d_noise", i),  32'(noise_ctrl), 32'(vecs[i].noise));
        end

        // Strobe held through BUSY: one commit, READY rises one cycle after release
        @(negedge CLK);
        nCE = 1'b0; nWE = 1'b0; D = 8'hE5;
        low = 0; pulses = 0;
        repeat (3 * BC) begin
            @(negedge CLK);
            if (noise_rst) pulses++;
            if (!READY) low++;
        end
        nCE = 1'b1; nWE = 1'b1;
        check("hold_low",    32'(low), 32'(3 * BC));
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_noise",  32'(noise_ctrl), 32'd5);
        @(negedge CLK);
        check("hold_ready_after_release", 32'(READY), 32'd1);

        // Only nWE low: ignored
        nCE = 1'b1; nWE = 1'b0; D = 8'h80;
        low = 0;
        repeat (5) begin
            @(negedge CLK);
            if (!READY) low++;
        end
        nWE = 1'b1;
        check("nwe_only_low",   32'(low), 32'd0);
        check("nwe_only_tones", 32'({tone2, tone1, tone0}), 32'({10'h000, 10'h3FF, 10'h0EA}));

        // Reset during BUSY aborts the write
        @(negedge CLK);
        nCE = 1'b0; nWE = 1'b0; D = 8'hC5;
        @(negedge CLK);
        check("abort_busy", 32'(READY), 32'd0);
        nCE = 1'b1; nWE = 1'b1; RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_ready", 32'(READY), 32'd1);
        check("abort_tone2", 32'(tone2), 32'd0);
        check("abort_atts",  32'({atten3, atten2, atten1, atten0}), 32'hFFFF);
        check("abort_nrst",  32'(noise_rst), 32'd0);

        // Data byte after reset targets tone0 high bits
        write_byte(8'h3F, low, pulses);
        check("post_rst_low",   32'(low), 32'(BC));
        check("post_rst_tone0", 32'(tone0), 32'h3F0);
        check("post_rst_tone2", 32'(tone2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
